// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter. The memory stage also reuses
// mem_req_t and the external-port state names.
package dmem_arb_pkg;

  typedef enum logic {
    E_IDLE = 1'b0,
    E_ACK  = 1'b1
  } ext_state_e;

  // Widest SRAM word address any instance can use (byte address bits [31:2])
  localparam int MEM_WORD_AW = 30;

  typedef struct packed {
    logic [3:0]             we;
    logic [MEM_WORD_AW-1:0] addr;
    logic [31:0]            wdata;
  } mem_req_t;

  // A counter that only ever holds zero still needs one bit
  function automatic int starve_cnt_w(input int starve_max);
    return (starve_max < 1) ? 1 : $clog2(starve_max + 1);
  endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data SRAM between the core load/store path and a
// Wishbone-classic slave port. Core has priority, bounded by a starvation counter.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MEM_AW     = 10,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [3:0]        core_be_i,
  input  logic [31:0]       core_addr_i,
  input  logic [31:0]       core_wdata_i,
  output logic              core_gnt_o,
  output logic              core_rvalid_o,
  output logic [31:0]       core_rdata_o,
  output logic              stall_o,
  input  logic              ext_cyc_i,
  input  logic              ext_stb_i,
  input  logic              ext_we_i,
  input  logic [3:0]        ext_sel_i,
  input  logic [31:0]       ext_adr_i,
  input  logic [31:0]       ext_dat_i,
  output logic              ext_ack_o,
  output logic [31:0]       ext_dat_o,
  output logic              mem_en_o,
  output logic [3:0]        mem_we_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);

  localparam int                CNT_W      = starve_cnt_w(STARVE_MAX);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  ext_state_e       state;
  logic [CNT_W-1:0] starve_cnt;
  logic             rd_core_p1;
  logic             ext_we_p1;

  logic     ext_req;
  logic     grant_ext;
  logic     grant_core;
  mem_req_t req;

  assign ext_req    = ext_cyc_i & ext_stb_i & (state == E_IDLE);
  assign grant_ext  = ext_req & (~core_req_i | (starve_cnt >= STARVE_LIM));
  assign grant_core = core_req_i & ~grant_ext;

  always_comb begin
    req = '0;
    if (grant_core) begin
      req.we    = core_we_i ? core_be_i : 4'b0000;
      req.addr  = MEM_WORD_AW'(core_addr_i[MEM_AW+1:2]);
      req.wdata = core_wdata_i;
    end else if (grant_ext) begin
      req.we    = ext_we_i ? ext_sel_i : 4'b0000;
      req.addr  = MEM_WORD_AW'(ext_adr_i[MEM_AW+1:2]);
      req.wdata = ext_dat_i;
    end
  end

  assign mem_en_o    = grant_core | grant_ext;
  assign mem_we_o    = req.we;
  assign mem_addr_o  = req.addr[MEM_AW-1:0];
  assign mem_wdata_o = req.wdata;

  // Address bits outside the SRAM word index alias onto the same word
  logic unused_addr_bits;
  assign unused_addr_bits = ^{core_addr_i[31:MEM_AW+2], core_addr_i[1:0],
                              ext_adr_i[31:MEM_AW+2], ext_adr_i[1:0],
                              req.addr[MEM_WORD_AW-1:MEM_AW]};

  assign core_gnt_o = grant_core;
  assign stall_o    = core_req_i & ~grant_core;

  // Stage p1: SRAM read data returns one cycle after the grant
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= E_IDLE;
      starve_cnt <= '0;
      rd_core_p1 <= 1'b0;
      ext_we_p1  <= 1'b0;
    end else begin
      rd_core_p1 <= grant_core & ~core_we_i;
      case (state)
        E_IDLE: begin
          if (grant_ext) begin
            state     <= E_ACK;
            ext_we_p1 <= ext_we_i;
          end
        end
        E_ACK:   state <= E_IDLE;
        default: state <= E_IDLE;
      endcase
      if (grant_ext || !ext_req)
        starve_cnt <= '0;
      else if (starve_cnt < STARVE_LIM)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign core_rvalid_o = rd_core_p1;
  assign core_rdata_o  = rd_core_p1 ? mem_rdata_i : 32'h0;

  // A master that drops cyc mid-transfer gets no ack; any write already landed
  assign ext_ack_o = (state == E_ACK) & ext_cyc_i;
  assign ext_dat_o = ((state == E_ACK) && !ext_we_p1) ? mem_rdata_i : 32'h0;

endmodule
